// File: rtl/conv_stream_param.sv
// Streaming 1-D valid-region convolution engine.
// Loads x[N] and f[M], then emits the N-M+1 outputs while accumulating P products per cycle.
module conv_stream_param #(
    parameter int N  = 128,
    parameter int M  = 32,
    parameter int P  = 8,
    parameter int XW = 8,
    parameter int FW = 8,
    parameter int YW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] s_data_in_x,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    input  logic [FW-1:0] s_data_in_f,
    input  logic          s_valid_f,
    output logic          s_ready_f,
    input  logic          keep_f,
    output logic [YW-1:0] m_data_out_y,
    output logic          m_valid_y,
    input  logic          m_ready_y,
    output logic          busy
);
    localparam int G   = M / P;
    localparam int IW  = $clog2(N);
    localparam int FIW = (M > 1) ? $clog2(M) : 1;
    localparam int CW  = $clog2(N + 1);
    localparam int FCW = $clog2(M + 1);
    localparam int GW  = (G > 1) ? $clog2(G) : 1;
    localparam int PW  = (XW + FW > YW) ? XW + FW : YW;

    localparam logic [CW-1:0]  X_FULL = CW'(N);
    localparam logic [FCW-1:0] F_FULL = FCW'(M);
    localparam logic [IW-1:0]  K_LAST = IW'(N - M);
    localparam logic [GW-1:0]  G_LAST = GW'(G - 1);
    localparam logic [FIW-1:0] P_F    = FIW'(P);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [FCW-1:0] f_cnt_q, f_cnt_d;
    logic [IW-1:0] k_q, k_d;
    logic [GW-1:0] g_q, g_d;
    logic          f_loaded_q, f_loaded_d;
    logic [YW-1:0] acc_q, acc_d;
    logic [YW-1:0] y_q, y_d;
    logic          live_q;

    logic [XW-1:0] xbuf_q [N];
    logic [FW-1:0] fbuf_q [M];

    logic          x_fire, f_fire;
    logic [FIW-1:0] base_f, fi;
    logic [IW-1:0]  base_x, xi;
    logic signed [PW-1:0] xe, fe, prod_sum;

    // live_q keeps the readies low on the cycle right after a reset edge.
    assign s_ready_x    = live_q && (state_q == ST_LOAD) && (x_cnt_q < X_FULL);
    assign s_ready_f    = live_q && (state_q == ST_LOAD) && !f_loaded_q && (f_cnt_q < F_FULL);
    assign m_valid_y    = (state_q == ST_OUTPUT);
    assign m_data_out_y = y_q;
    assign busy         = (state_q != ST_LOAD);

    assign x_fire = s_valid_x && s_ready_x;
    assign f_fire = s_valid_f && s_ready_f;

    // Sum of the P products for group g of output k, wrapping at PW bits.
    always_comb begin
        base_f   = FIW'(g_q) * P_F;
        base_x   = k_q + IW'(base_f);
        prod_sum = '0;
        xi       = '0;
        fi       = '0;
        xe       = '0;
        fe       = '0;
        for (int i = 0; i < P; i++) begin
            xi       = base_x + IW'(i);
            fi       = base_f + FIW'(i);
            xe       = PW'($signed(xbuf_q[xi]));
            fe       = PW'($signed(fbuf_q[fi]));
            prod_sum = prod_sum + xe * fe;
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        x_cnt_d    = x_cnt_q;
        f_cnt_d    = f_cnt_q;
        k_d        = k_q;
        g_d        = g_q;
        f_loaded_d = f_loaded_q;
        acc_d      = acc_q;
        y_d        = y_q;
        case (state_q)
            ST_LOAD: begin
                if (x_fire) x_cnt_d = x_cnt_q + CW'(1);
                if (f_fire) f_cnt_d = f_cnt_q + FCW'(1);
                if ((x_cnt_d == X_FULL) && ((f_cnt_d == F_FULL) || f_loaded_q)) begin
                    state_d = ST_COMPUTE;
                    k_d     = '0;
                    g_d     = '0;
                end
            end
            ST_COMPUTE: begin
                acc_d = ((g_q == '0) ? '0 : acc_q) + YW'(prod_sum);
                if (g_q == G_LAST) begin
                    y_d     = acc_d;
                    state_d = ST_OUTPUT;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            ST_OUTPUT: begin
                if (m_ready_y) begin
                    if (k_q != K_LAST) begin
                        k_d     = k_q + IW'(1);
                        g_d     = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        f_loaded_d = keep_f;
                        x_cnt_d    = '0;
                        if (!keep_f) f_cnt_d = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            x_cnt_q    <= '0;
            f_cnt_q    <= '0;
            k_q        <= '0;
            g_q        <= '0;
            f_loaded_q <= 1'b0;
            acc_q      <= '0;
            y_q        <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_cnt_q    <= x_cnt_d;
            f_cnt_q    <= f_cnt_d;
            k_q        <= k_d;
            g_q        <= g_d;
            f_loaded_q <= f_loaded_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            live_q     <= 1'b1;
        end
    end

    // NOTE: sample buffers are not reset; the counters alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (x_fire) xbuf_q[IW'(x_cnt_q)] <= s_data_in_x;
        if (f_fire) fbuf_q[FIW'(f_cnt_q)] <= s_data_in_f;
    end

endmodule

// File: tb/tb_conv_stream_param.sv
// Self-checking bench for conv_stream_param: default and small configurations,
// random valid/ready traffic checked against a direct sum-of-products model.
module tb_conv_stream_param;
    localparam int NA = 128, MA = 32, PA = 8, YWA = 21;
    localparam int NB = 16,  MB = 4,  PB = 2, YWB = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] dx, df;
    logic vx = 1'b0, vf = 1'b0, keep = 1'b0, mr = 1'b0;
    logic sel = 1'b0;

    logic rx_a, rf_a, mv_a, bz_a;
    logic [YWA-1:0] y_a;
    logic rx_b, rf_b, mv_b, bz_b;
    logic [YWB-1:0] y_b;

    logic rx, rf, mv, bz;
    integer y_obs;

    always #5 clk = ~clk;

    conv_stream_param #(.N(NA), .M(MA), .P(PA), .XW(8), .FW(8), .YW(YWA)) u_dut_a (
        .clk(clk), .reset(rst_n),
        .s_data_in_x(dx), .s_valid_x(vx && !sel), .s_ready_x(rx_a),
        .s_data_in_f(df), .s_valid_f(vf && !sel), .s_ready_f(rf_a),
        .keep_f(keep),
        .m_data_out_y(y_a), .m_valid_y(mv_a), .m_ready_y(mr && !sel),
        .busy(bz_a)
    );

    conv_stream_param #(.N(NB), .M(MB), .P(PB), .XW(8), .FW(8), .YW(YWB)) u_dut_b (
        .clk(clk), .reset(rst_n),
        .s_data_in_x(dx), .s_valid_x(vx && sel), .s_ready_x(rx_b),
        .s_data_in_f(df), .s_valid_f(vf && sel), .s_ready_f(rf_b),
        .keep_f(keep),
        .m_data_out_y(y_b), .m_valid_y(mv_b), .m_ready_y(mr && sel),
        .busy(bz_b)
    );

    always_comb begin
        rx = sel ? rx_b : rx_a;
        rf = sel ? rf_b : rf_a;
        mv = sel ? mv_b : mv_a;
        bz = sel ? bz_b : bz_a;
        if (sel) y_obs = $signed(y_b);
        else     y_obs = $signed(y_a);
    end

    int errs = 0, checks = 0;
    int cur_n = NA, cur_m = MA, cur_g = MA / PA, cur_yw = YWA;
    int xv [NA];
    int fv [MA];
    int vpct = 100, rpct = 100, stall_k = -1, rst_k = -1, order = 0;
    integer last_y;

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap(input int v);
        logic [31:0] t;
        t = v;
        t = t << (32 - cur_yw);
        return int'($signed(t) >>> (32 - cur_yw));
    endfunction

    function automatic int gold(input int k);
        int s = 0;
        for (int j = 0; j < cur_m; j++) s += xv[k + j] * fv[j];
        return wrap(s);
    endfunction

    task automatic fill_rand_x();
        for (int i = 0; i < cur_n; i++) xv[i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic fill_rand_f();
        for (int i = 0; i < cur_m; i++) fv[i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic fill_const(input int xval, input int fval);
        for (int i = 0; i < cur_n; i++) xv[i] = xval;
        for (int i = 0; i < cur_m; i++) fv[i] = fval;
    endtask

    // Streams one vector (and optionally a filter) and checks every output.
    task automatic run_vec(input bit send_f, input bit keep_v, input string tag);
        int xi = 0, fi = 0, yi = 0, cyc = 0;
        int nout, nf;
        int load_c = -1, prev_fire_c = -1, last_x_c = -1, last_f_c = -1;
        int bad_gap = 0, bad_hold = 0, rf_seen = 0;
        bit prev_mv = 1'b0, want_vx, want_vf;
        integer held_y;
        nout = cur_n - cur_m + 1;
        nf   = send_f ? cur_m : 0;
        while (yi < nout && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (mv && !prev_mv) begin
                if (prev_fire_c < 0) check({tag, " latency"}, cyc - load_c, cur_g + 1);
                else if (cyc - prev_fire_c != cur_g + 1) bad_gap++;
            end
            prev_mv = mv;
            if (!send_f && rf) rf_seen++;

            if (rst_k >= 0 && yi == rst_k && prev_fire_c >= 0 && cyc == prev_fire_c + 2) begin
                rst_n = 1'b0; vx = 1'b0; vf = 1'b0; mr = 1'b0;
                @(negedge clk);
                check({tag, " rst rdy_x"}, rx, 0);
                check({tag, " rst rdy_f"}, rf, 0);
                check({tag, " rst valid"}, mv, 0);
                check({tag, " rst y"}, y_obs, 0);
                check({tag, " rst busy"}, bz, 0);
                rst_n = 1'b1;
                @(negedge clk);
                check({tag, " post rdy_x"}, rx, 1);
                check({tag, " post rdy_f"}, rf, 1);
                rst_k = -1;
                return;
            end

            want_vx = (xi < cur_n) && ($urandom_range(99) < vpct);
            want_vf = (fi < nf) && ($urandom_range(99) < vpct);
            if (order == 1 && fi < nf) want_vx = 1'b0;
            if (order == 2) begin
                if (xi == cur_n - 1 && fi < nf - 1) want_vx = 1'b0;
                if (fi == nf - 1 && xi < cur_n - 1) want_vf = 1'b0;
            end
            vx = want_vx;
            dx = want_vx ? 8'(xv[xi]) : 8'($urandom);
            vf = want_vf;
            df = want_vf ? 8'(fv[fi]) : 8'($urandom);
            mr = ($urandom_range(99) < rpct);
            keep = (yi == nout - 1) ? keep_v : 1'($urandom);

            if (stall_k >= 0 && yi == stall_k && mv) begin
                held_y = y_obs;
                mr = 1'b0; vx = 1'b1; vf = 1'b1;
                repeat (50) begin
                    @(negedge clk);
                    cyc++;
                    if (!(mv === 1'b1 && y_obs === held_y && rx === 1'b0 && rf === 1'b0)) bad_hold++;
                end
                check({tag, " stall hold"}, bad_hold, 0);
                stall_k = -1;
                vx = 1'b0; vf = 1'b0; want_vx = 1'b0; want_vf = 1'b0; mr = 1'b1;
            end

            if (mv && mr) begin
                check($sformatf("%s y%0d", tag, yi), y_obs, gold(yi));
                last_y = y_obs;
                yi++;
                prev_fire_c = cyc;
            end
            if (want_vx && rx) begin xi++; last_x_c = cyc; end
            if (want_vf && rf) begin fi++; last_f_c = cyc; end
            if (((want_vx && rx) || (want_vf && rf)) && xi == cur_n && fi == nf) load_c = cyc;
        end
        vx = 1'b0; vf = 1'b0;
        if (yi < nout) begin
            check({tag, " timeout outputs"}, yi, nout);
            return;
        end
        @(negedge clk);
        check({tag, " end valid"}, mv, 0);
        check({tag, " end rdy_x"}, rx, 1);
        check({tag, " end rdy_f"}, rf, keep_v ? 0 : 1);
        check({tag, " gaps"}, bad_gap, 0);
        if (!send_f) check({tag, " rdy_f held low"}, rf_seen, 0);
        if (order == 2) check({tag, " same edge"}, last_x_c, last_f_c);
    endtask

    initial begin
        dx = '0; df = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rdy_x", rx, 0);
        check("reset rdy_f", rf, 0);
        check("reset valid", mv, 0);
        check("reset y", y_obs, 0);
        check("reset busy", bz, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release rdy_x", rx, 1);
        check("release rdy_f", rf, 1);

        vpct = 60; rpct = 60;
        for (int v = 0; v < 3; v++) begin
            fill_rand_x(); fill_rand_f();
            run_vec(1'b1, 1'b0, $sformatf("rnd%0d", v));
        end

        vpct = 100; rpct = 100;
        fill_const(1, 1);
        run_vec(1'b1, 1'b0, "ones");
        check("ones value", last_y, 32);
        fill_const(-128, -128);
        run_vec(1'b1, 1'b0, "negmax");
        check("negmax value", last_y, 524288);
        fill_const(127, -128);
        run_vec(1'b1, 1'b0, "mixed");
        check("mixed value", last_y, -520192);

        vpct = 70; rpct = 70;
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b1, "retA");
        fill_rand_x();
        run_vec(1'b0, 1'b0, "retB");
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "retC");

        vpct = 100; rpct = 100; stall_k = 5;
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "bp");

        rst_k = 40;
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "rst");
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "fresh");

        sel = 1'b1;
        cur_n = NB; cur_m = MB; cur_g = MB / PB; cur_yw = YWB;
        @(negedge clk);
        vpct = 60; rpct = 60; order = 0;
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "s_rnd");
        vpct = 100; rpct = 100; order = 1;
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "s_ffirst");
        order = 2;
        fill_rand_x(); fill_rand_f();
        run_vec(1'b1, 1'b0, "s_same");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
